memctrl_gen: RTL and testbench
==============================

MEMCTRL_GEN -- requirements
Module: memctrl_gen

Interface
REQ-001 Parameter BANK_W, default 8: width of bank register; legal 5..8.
REQ-002 Parameter FIFO_DEPTH, default 16: keyboard scancode FIFO entries; power of two, 2..256.
REQ-003 Parameter WIN_BASE, default 16'hF000: base of 4 KB banked window; must be 4 KB aligned.
REQ-004 Parameter IO_BASE, default 16'h0020: base of 8-byte control register block.
REQ-005 Ports: clock in 1 (the one clock); reset_n in 1 (reset is asynchronous and active-low).
REQ-006 address in 16, CPU data address; wren in 1, CPU write strobe; rd in 1, CPU read strobe; data_o in 8, CPU write data.
REQ-007 data_i out 8: read data to CPU.
REQ-008 data_o_sram, data_o_text, data_o_grph in 8: memory read data.
REQ-009 data_w_sram, data_w_text, data_w_grph out 1: memory write enables.
REQ-010 bank out BANK_W; videomode out 8; cursor_x, cursor_y out 8.
REQ-011 ps2_data in 8, ps2_hit in 1: scancode and strobe, already in clock domain.
REQ-012 kbd_irq out 1: high while FIFO non-empty.

Function
REQ-013 Decode (combinational): IO when address in IO_BASE..IO_BASE+7; WIN when address in WIN_BASE..WIN_BASE+4095; else SRAM.
REQ-014 WIN targets text memory when target register bit0 = 0, graphics when 1.
REQ-015 Each write enable = wren AND its region selected; IO writes assert none of them.
REQ-016 data_i muxes data_o_sram, data_o_text or data_o_grph by region; IO reads return register value; no added latency.
REQ-017 IO offsets: 0 bank, 1 videomode, 2 cursor_x, 3 cursor_y, 4 kbd data, 5 kbd status, 6 window target, 7 FIFO count.
REQ-018 Offsets 0,1,2,3,6: read/write, update on the clock edge with wren; bank keeps low BANK_W bits; offset 6 keeps bit0, reads upper bits 0.
REQ-019 Offset 4 read returns FIFO head; the edge with rd asserted pops one entry; read when empty returns 8'h00 and does not pop; writes ignored.
REQ-020 Offset 5 status: bit0 non-empty, bit1 overflow (sticky), bit2 full; write with data bit1 = 1 clears overflow.
REQ-021 Push on the cycle after a 0->1 transition of ps2_hit; a level held high pushes once.
REQ-022 Push when full drops the byte and sets overflow.
REQ-023 Simultaneous push and pop on a non-full, non-empty FIFO: count unchanged, order preserved.
REQ-024 Simultaneous push and pop when full: pop succeeds, push accepted, no overflow.
REQ-025 Push and pop when empty: pop ignored, push accepted.
REQ-026 Read/write pointers wrap modulo FIFO_DEPTH; offset 7 reads count, saturated at 255.
REQ-027 Overflow set and cleared on the same edge: set wins.

Reset
REQ-028 On reset_n low, asynchronously: bank 0, videomode 0, cursors 0, target 0, FIFO empty, overflow 0, edge detector 0, kbd_irq 0.
REQ-029 Reset mid-operation discards FIFO contents; the first ps2_hit high sampled after release counts as a rising edge.

Configuration
REQ-030 Macro MEMCTRL_KBD_FIFO_EN defined: FIFO of FIFO_DEPTH as above.
REQ-031 Macro absent: single holding register; new scancode overwrites it, and overwriting while full sets overflow; full is the same as non-empty; count is 0 or 1; FIFO_DEPTH ignored.

Structure
REQ-032 Shared package memctrl_pkg holds IO offset constants, region enum (SRAM, IO, WIN) and target enum (TEXT, GRPH).
REQ-033 One sub-module kbd_fifo (push, pop, data, count, full, empty, overflow) is instantiated; the decoder and registers stay in memctrl_gen.

Verification
REQ-034 Write 8'h05 to IO_BASE+0, then wren at 16'hF123 with target 0 -> data_w_text pulses, bank = 5, data_w_sram stays 0.
REQ-035 Three ps2_hit pulses 8'h1C, 8'h32, 8'h21, then three rd at IO_BASE+4 -> 1C, 32, 21 returned, count 3->0, kbd_irq falls after third pop.
REQ-036 FIFO_DEPTH+1 pushes with no pops -> status reads 8'h07; write 8'h02 to IO_BASE+5 -> status reads 8'h05.
REQ-037 FIFO full, push and pop on the same edge -> count stays FIFO_DEPTH, overflow 0, next read returns the second-oldest byte.
REQ-038 rd at IO_BASE+4 when empty -> data_i 8'h00, count stays 0; ps2_hit held high 10 cycles -> exactly one push.
REQ-039 reset_n pulsed low mid-sequence with 4 entries queued -> all outputs at reset values immediately, count 0, without waiting for a clock edge.

Source files
------------

// File: rtl/memctrl_pkg.sv
// Shared definitions for memctrl_gen: control-block register offsets, address
// region and window-target encodings, and the keyboard count saturation helper.
package memctrl_pkg;

  localparam logic [2:0] OFF_BANK  = 3'd0;
  localparam logic [2:0] OFF_VMODE = 3'd1;
  localparam logic [2:0] OFF_CURX  = 3'd2;
  localparam logic [2:0] OFF_CURY  = 3'd3;
  localparam logic [2:0] OFF_KDATA = 3'd4;
  localparam logic [2:0] OFF_KSTAT = 3'd5;
  localparam logic [2:0] OFF_TGT   = 3'd6;
  localparam logic [2:0] OFF_KCNT  = 3'd7;

  typedef enum logic [1:0] {RGN_SRAM, RGN_IO, RGN_WIN} region_e;
  typedef enum logic {TGT_TEXT = 1'b0, TGT_GRPH = 1'b1} target_e;

  // The count register is 8 bits wide; a 256-entry FIFO reports 255 when full.
  function automatic logic [7:0] sat_count(input logic [8:0] c);
    return c[8] ? 8'hFF : c[7:0];
  endfunction

endpackage

// File: rtl/kbd_fifo.sv
// Keyboard scancode store. With MEMCTRL_KBD_FIFO_EN defined it is a DEPTH-entry
// FIFO; otherwise a single holding register that newer scancodes overwrite.
// Overflow is sticky, cleared by ovf_clr; a set on the same edge wins.
module kbd_fifo
  import memctrl_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  input  logic       ovf_clr,
  output logic [7:0] rd_data,
  output logic [7:0] count,
  output logic       full,
  output logic       empty,
  output logic       overflow
);

`ifdef MEMCTRL_KBD_FIFO_EN
  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic          do_push, do_pop, ovf_set;

  // DEPTH is a power of two, so the count MSB alone marks full.
  assign full     = cnt_q[AW];
  assign empty    = (cnt_q == '0);
  assign rd_data  = mem_q[rd_ptr_q];
  assign count    = sat_count(9'(cnt_q));
  assign overflow = ovf_q;

  // Accept a push when full only if a pop frees the head slot on the same edge.
  always_comb begin
    do_pop   = pop & ~empty;
    do_push  = push & (~full | do_pop);
    ovf_set  = push & full & ~do_pop;
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    cnt_d    = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    ovf_d    = ovf_set | (ovf_q & ~ovf_clr);
  end

  // Storage array carries no reset; only pointers/count define validity.
  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  // Pointer, count and overflow state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
    end
  end
`else
  logic [7:0] data_q, data_d;
  logic       vld_q, vld_d;
  logic       ovf_q, ovf_d;
  logic       unused_depth;

  assign unused_depth = (DEPTH > 0);
  assign rd_data      = data_q;
  assign count        = {7'b0, vld_q};
  assign full         = vld_q;
  assign empty        = ~vld_q;
  assign overflow     = ovf_q;

  // New scancode always lands; losing an unread one flags overflow.
  always_comb begin
    data_d = data_q;
    vld_d  = vld_q;
    ovf_d  = ovf_q & ~ovf_clr;
    if (push) begin
      data_d = push_data;
      vld_d  = 1'b1;
      if (vld_q & ~pop) ovf_d = 1'b1;
    end else if (pop) begin
      vld_d = 1'b0;
    end
  end

  // Holding register state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      data_q <= 8'h00;
      vld_q  <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      data_q <= data_d;
      vld_q  <= vld_d;
      ovf_q  <= ovf_d;
    end
  end
`endif

endmodule

// File: rtl/memctrl_gen.sv
// CPU-side memory controller: decodes the CPU address into SRAM, an 8-byte
// control block and a 4 KB banked window (text or graphics), muxes read data
// with no added latency, and holds the control registers plus keyboard buffer.
// Optional feature: define MEMCTRL_KBD_FIFO_EN for a FIFO_DEPTH scancode FIFO;
// without it a single holding register is used.
module memctrl_gen
  import memctrl_pkg::*;
#(
  parameter int          BANK_W     = 8,
  parameter int          FIFO_DEPTH = 16,
  parameter logic [15:0] WIN_BASE   = 16'hF000,
  parameter logic [15:0] IO_BASE    = 16'h0020
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [15:0]       address,
  input  logic              wren,
  input  logic              rd,
  input  logic [7:0]        data_o,
  output logic [7:0]        data_i,
  input  logic [7:0]        data_o_sram,
  input  logic [7:0]        data_o_text,
  input  logic [7:0]        data_o_grph,
  output logic              data_w_sram,
  output logic              data_w_text,
  output logic              data_w_grph,
  output logic [BANK_W-1:0] bank,
  output logic [7:0]        videomode,
  output logic [7:0]        cursor_x,
  output logic [7:0]        cursor_y,
  input  logic [7:0]        ps2_data,
  input  logic              ps2_hit,
  output logic              kbd_irq
);

  region_e           rgn;
  logic [15:0]       io_diff;
  logic [2:0]        io_off;
  logic              io_wr;
  logic [7:0]        io_rdata;

  logic [BANK_W-1:0] bank_q, bank_d;
  logic [7:0]        vmode_q, vmode_d;
  logic [7:0]        curx_q, curx_d;
  logic [7:0]        cury_q, cury_d;
  target_e           tgt_q, tgt_d;
  logic              hit_q, hit_d;

  logic              kbd_push, kbd_pop, kbd_clr;
  logic [7:0]        kbd_data, kbd_count;
  logic              kbd_full, kbd_empty, kbd_ovf;

  // Address decode; the control block takes priority should it overlap the window.
  always_comb begin
    io_diff = address - IO_BASE;
    io_off  = io_diff[2:0];
    rgn     = RGN_SRAM;
    if ((address >= IO_BASE) && (io_diff < 16'd8)) rgn = RGN_IO;
    else if (address[15:12] == WIN_BASE[15:12])    rgn = RGN_WIN;
  end

  assign io_wr       = wren & (rgn == RGN_IO);
  assign data_w_sram = wren & (rgn == RGN_SRAM);
  assign data_w_text = wren & (rgn == RGN_WIN) & (tgt_q == TGT_TEXT);
  assign data_w_grph = wren & (rgn == RGN_WIN) & (tgt_q == TGT_GRPH);

  // Keyboard strobes: rising edge of ps2_hit pushes, read of the data port pops.
  assign kbd_push = ps2_hit & ~hit_q;
  assign kbd_pop  = rd & (rgn == RGN_IO) & (io_off == OFF_KDATA);
  assign kbd_clr  = io_wr & (io_off == OFF_KSTAT) & data_o[1];

  // Control register writes.
  always_comb begin
    bank_d  = bank_q;
    vmode_d = vmode_q;
    curx_d  = curx_q;
    cury_d  = cury_q;
    tgt_d   = tgt_q;
    hit_d   = ps2_hit;
    if (io_wr) begin
      case (io_off)
        OFF_BANK:  bank_d  = data_o[BANK_W-1:0];
        OFF_VMODE: vmode_d = data_o;
        OFF_CURX:  curx_d  = data_o;
        OFF_CURY:  cury_d  = data_o;
        OFF_TGT:   tgt_d   = target_e'(data_o[0]);
        default:   ;
      endcase
    end
  end

  // Control register and edge-detector state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bank_q  <= '0;
      vmode_q <= 8'h00;
      curx_q  <= 8'h00;
      cury_q  <= 8'h00;
      tgt_q   <= TGT_TEXT;
      hit_q   <= 1'b0;
    end else begin
      bank_q  <= bank_d;
      vmode_q <= vmode_d;
      curx_q  <= curx_d;
      cury_q  <= cury_d;
      tgt_q   <= tgt_d;
      hit_q   <= hit_d;
    end
  end

  // Control block read-back.
  always_comb begin
    io_rdata = 8'h00;
    case (io_off)
      OFF_BANK:  io_rdata = 8'(bank_q);
      OFF_VMODE: io_rdata = vmode_q;
      OFF_CURX:  io_rdata = curx_q;
      OFF_CURY:  io_rdata = cury_q;
      OFF_KDATA: io_rdata = kbd_empty ? 8'h00 : kbd_data;
      OFF_KSTAT: io_rdata = {5'b0, kbd_full, kbd_ovf, ~kbd_empty};
      OFF_TGT:   io_rdata = {7'b0, tgt_q};
      OFF_KCNT:  io_rdata = kbd_count;
      default:   io_rdata = 8'h00;
    endcase
  end

  // CPU read data mux.
  always_comb begin
    data_i = data_o_sram;
    case (rgn)
      RGN_IO:  data_i = io_rdata;
      RGN_WIN: data_i = (tgt_q == TGT_GRPH) ? data_o_grph : data_o_text;
      default: data_i = data_o_sram;
    endcase
  end

  kbd_fifo #(.DEPTH(FIFO_DEPTH)) u_kbd (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (kbd_push),
    .push_data (ps2_data),
    .pop       (kbd_pop),
    .ovf_clr   (kbd_clr),
    .rd_data   (kbd_data),
    .count     (kbd_count),
    .full      (kbd_full),
    .empty     (kbd_empty),
    .overflow  (kbd_ovf)
  );

  assign bank      = bank_q;
  assign videomode = vmode_q;
  assign cursor_x  = curx_q;
  assign cursor_y  = cury_q;
  assign kbd_irq   = ~kbd_empty;

endmodule

// File: tb/tb_memctrl_gen.sv
// Bench for memctrl_gen: a queue-based model of the address map, registers and
// scancode buffer is checked against the DUT every falling edge, with directed
// literal checks pinning the key scenarios, then a randomized phase.
module tb_memctrl_gen;

  localparam int          BW    = 6;
  localparam int          DEPTH = 16;
  localparam logic [15:0] WB    = 16'hF000;
  localparam logic [15:0] IOB   = 16'h0020;
`ifdef MEMCTRL_KBD_FIFO_EN
  localparam int          CAP     = DEPTH;
  localparam logic [7:0]  PP_HEAD = 8'h40;
  localparam logic [7:0]  PP_NEXT = 8'h41;
`else
  localparam int          CAP     = 1;
  localparam logic [7:0]  PP_HEAD = 8'h41;
  localparam logic [7:0]  PP_NEXT = 8'hEE;
`endif
  localparam logic [7:0]  Q4 = 8'((CAP < 4) ? CAP : 4);

  logic          clock = 1'b0, reset_n = 1'b0;
  logic [15:0]   address = 16'h0;
  logic          wren = 1'b0, rd = 1'b0;
  logic [7:0]    data_o = 8'h0;
  logic [7:0]    data_i;
  logic [7:0]    data_o_sram = 8'h0, data_o_text = 8'h0, data_o_grph = 8'h0;
  logic          data_w_sram, data_w_text, data_w_grph;
  logic [BW-1:0] bank;
  logic [7:0]    videomode, cursor_x, cursor_y;
  logic [7:0]    ps2_data = 8'h0;
  logic          ps2_hit = 1'b0;
  logic          kbd_irq;

  int n_checks = 0;
  int n_fail   = 0;

  memctrl_gen #(.BANK_W(BW), .FIFO_DEPTH(DEPTH), .WIN_BASE(WB), .IO_BASE(IOB)) dut (
    .clock(clock), .reset_n(reset_n), .address(address), .wren(wren), .rd(rd),
    .data_o(data_o), .data_i(data_i), .data_o_sram(data_o_sram),
    .data_o_text(data_o_text), .data_o_grph(data_o_grph),
    .data_w_sram(data_w_sram), .data_w_text(data_w_text), .data_w_grph(data_w_grph),
    .bank(bank), .videomode(videomode), .cursor_x(cursor_x), .cursor_y(cursor_y),
    .ps2_data(ps2_data), .ps2_hit(ps2_hit), .kbd_irq(kbd_irq)
  );

  always #5 clock = ~clock;

  // ---------------- reference model ----------------
  int         m_bank = 0, m_vmode = 0, m_cx = 0, m_cy = 0, m_tgt = 0;
  bit         m_ovf = 0, m_prev = 0;
  logic [7:0] mq[$];

  function automatic int region_of(input int a);
    if (a >= int'(IOB) && a <= int'(IOB) + 7) return 1;
    if (a >= int'(WB) && a <= int'(WB) + 4095) return 2;
    return 0;
  endfunction

  function automatic logic [7:0] exp_io(input int off);
    case (off)
      0: return 8'(m_bank);
      1: return 8'(m_vmode);
      2: return 8'(m_cx);
      3: return 8'(m_cy);
      4: return (mq.size() > 0) ? mq[0] : 8'h00;
      5: return 8'(((mq.size() == CAP) ? 4 : 0) + (m_ovf ? 2 : 0) + ((mq.size() > 0) ? 1 : 0));
      6: return 8'(m_tgt);
      default: return 8'((mq.size() > 255) ? 255 : mq.size());
    endcase
  endfunction

  function automatic logic [7:0] exp_data_i();
    int r;
    r = region_of(int'(address));
    if (r == 0) return data_o_sram;
    if (r == 2) return (m_tgt != 0) ? data_o_grph : data_o_text;
    return exp_io(int'(address) - int'(IOB));
  endfunction

  function automatic logic [7:0] exp_we();
    int r;
    r = region_of(int'(address));
    if (!wren) return 8'h00;
    if (r == 0) return 8'h01;
    if (r == 2) return (m_tgt != 0) ? 8'h04 : 8'h02;
    return 8'h00;
  endfunction

  // Model state advance on each clock edge; asynchronous reset clears it.
  initial begin : model
    int a, r, off;
    bit pop, push, clr, setov;
    forever begin
      @(posedge clock or negedge reset_n);
      if (!reset_n) begin
        m_bank = 0; m_vmode = 0; m_cx = 0; m_cy = 0; m_tgt = 0;
        m_ovf = 0; m_prev = 0; mq.delete();
      end else begin
        a     = int'(address);
        r     = region_of(a);
        off   = a - int'(IOB);
        pop   = rd && r == 1 && off == 4 && mq.size() > 0;
        push  = ps2_hit && !m_prev;
        clr   = wren && r == 1 && off == 5 && data_o[1];
        setov = 0;
        if (wren && r == 1) begin
          case (off)
            0: m_bank  = int'(data_o) % (1 << BW);
            1: m_vmode = int'(data_o);
            2: m_cx    = int'(data_o);
            3: m_cy    = int'(data_o);
            6: m_tgt   = int'(data_o[0]);
            default: ;
          endcase
        end
        if (pop) void'(mq.pop_front());
        if (push) begin
          if (mq.size() < CAP) mq.push_back(ps2_data);
          else begin
            setov = 1;
`ifndef MEMCTRL_KBD_FIFO_EN
            mq[0] = ps2_data;
`endif
          end
        end
        m_ovf  = setov ? 1'b1 : (clr ? 1'b0 : m_ovf);
        m_prev = ps2_hit;
      end
    end
  end

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  initial begin : compare
    forever begin
      @(negedge clock);
      chk("data_i", data_i, exp_data_i());
      chk("we", {5'b0, data_w_grph, data_w_text, data_w_sram}, exp_we());
      chk("bank", 8'(bank), 8'(m_bank));
      chk("videomode", videomode, 8'(m_vmode));
      chk("cursor_x", cursor_x, 8'(m_cx));
      chk("cursor_y", cursor_y, 8'(m_cy));
      chk("kbd_irq", {7'b0, kbd_irq}, (mq.size() > 0) ? 8'h01 : 8'h00);
    end
  end

  // Memory read data changes every cycle.
  initial begin : memdata
    forever begin
      @(posedge clock); #2;
      data_o_sram = 8'($urandom);
      data_o_text = 8'($urandom);
      data_o_grph = 8'($urandom);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clock); #2;
  endtask

  task automatic io_wr(input int off, input logic [7:0] v);
    address = IOB + 16'(off); data_o = v; wren = 1'b1; rd = 1'b0;
    step();
    wren = 1'b0;
  endtask

  task automatic io_rd(input int off, input logic [7:0] exp, input string nm);
    address = IOB + 16'(off); rd = 1'b1; wren = 1'b0;
    #1 chk(nm, data_i, exp);
    step();
    rd = 1'b0;
  endtask

  task automatic kbd_hit(input logic [7:0] b);
    ps2_data = b; ps2_hit = 1'b1;
    step();
    ps2_hit = 1'b0;
    step();
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin : main
    int sel;
    step(); step();
    chk("rst_bank", 8'(bank), 8'h00);
    chk("rst_vmode", videomode, 8'h00);
    chk("rst_irq", {7'b0, kbd_irq}, 8'h00);
    reset_n = 1'b1;
    step();

    // Bank write then window write to text memory.
    io_wr(0, 8'h05);
    address = 16'hF123; data_o = 8'hAA; wren = 1'b1;
    #1 chk("we_text", {5'b0, data_w_grph, data_w_text, data_w_sram}, 8'h02);
    chk("bank_5", 8'(bank), 8'h05);
    step(); wren = 1'b0;
    io_wr(0, 8'hC5);
    io_rd(0, 8'h05, "bank_mask");

    // Target register: bit0 only, graphics routing.
    io_wr(6, 8'hFF);
    io_rd(6, 8'h01, "tgt_rd1");
    address = 16'hF800; wren = 1'b1;
    #1 chk("we_grph", {5'b0, data_w_grph, data_w_text, data_w_sram}, 8'h04);
    step(); wren = 1'b0;
    io_wr(6, 8'hFE);
    io_rd(6, 8'h00, "tgt_rd0");

    // Decode boundaries.
    wren = 1'b1;
    address = IOB + 16'd8;  #1 chk("io_end", {5'b0, data_w_grph, data_w_text, data_w_sram}, 8'h01);
    address = IOB - 16'd1;  #1 chk("io_pre", {5'b0, data_w_grph, data_w_text, data_w_sram}, 8'h01);
    address = WB - 16'd1;   #1 chk("win_pre", {5'b0, data_w_grph, data_w_text, data_w_sram}, 8'h01);
    address = 16'hFFFF;     #1 chk("win_top", {5'b0, data_w_grph, data_w_text, data_w_sram}, 8'h02);
    address = IOB + 16'd4;  #1 chk("io_nowe", {5'b0, data_w_grph, data_w_text, data_w_sram}, 8'h00);
    wren = 1'b0;
    step();

    io_wr(1, 8'h33); io_wr(2, 8'h11); io_wr(3, 8'h22);
    chk("vmode_33", videomode, 8'h33);
    chk("curx_11", cursor_x, 8'h11);
    chk("cury_22", cursor_y, 8'h22);

    // Empty read and held strobe.
    io_rd(4, 8'h00, "empty_rd");
    io_rd(7, 8'h00, "empty_cnt");
    ps2_data = 8'h5A; ps2_hit = 1'b1;
    repeat (10) step();
    ps2_hit = 1'b0; step();
    io_rd(7, 8'h01, "held_cnt");
    io_rd(4, 8'h5A, "held_data");
    io_rd(7, 8'h00, "held_cnt0");

    // Three scancodes in order.
    kbd_hit(8'h1C); kbd_hit(8'h32); kbd_hit(8'h21);
`ifdef MEMCTRL_KBD_FIFO_EN
    io_rd(7, 8'h03, "cnt3");
    io_rd(4, 8'h1C, "pop1");
    io_rd(4, 8'h32, "pop2");
    chk("irq_hold", {7'b0, kbd_irq}, 8'h01);
    io_rd(4, 8'h21, "pop3");
    chk("irq_fall", {7'b0, kbd_irq}, 8'h00);
    io_rd(7, 8'h00, "cnt0");
`else
    io_rd(7, 8'h01, "cnt1");
    io_rd(5, 8'h07, "hold_ovf");
    io_rd(4, 8'h21, "hold_last");
    chk("irq_fall", {7'b0, kbd_irq}, 8'h00);
    io_wr(5, 8'h02);
    io_rd(5, 8'h00, "hold_clr");
`endif

    // Fill past capacity, then clear overflow.
    for (int i = 0; i <= CAP; i++) kbd_hit(8'h40 + 8'(i));
    io_rd(5, 8'h07, "stat_ovf");
    io_rd(7, 8'(CAP), "cnt_full");
    io_wr(5, 8'hFD);
    io_rd(5, 8'h07, "stat_noclr");
    io_wr(5, 8'h02);
    io_rd(5, 8'h05, "stat_clr");

    // Push and pop on the same edge while full.
    address = IOB + 16'd4; rd = 1'b1; ps2_data = 8'hEE; ps2_hit = 1'b1;
    #1 chk("pp_head", data_i, PP_HEAD);
    step();
    rd = 1'b0; ps2_hit = 1'b0;
    io_rd(7, 8'(CAP), "pp_cnt");
    io_rd(5, 8'h05, "pp_stat");
    io_rd(4, PP_NEXT, "pp_next");
    repeat (CAP) begin
      address = IOB + 16'd4; rd = 1'b1; step(); rd = 1'b0;
    end

    // Asynchronous reset with entries queued.
    kbd_hit(8'hA1); kbd_hit(8'hA2); kbd_hit(8'hA3); kbd_hit(8'hA4);
    io_rd(7, Q4, "q4_cnt");
    ps2_data = 8'h77; ps2_hit = 1'b1;
    #1 reset_n = 1'b0;
    #1 chk("arst_bank", 8'(bank), 8'h00);
    chk("arst_vmode", videomode, 8'h00);
    chk("arst_curx", cursor_x, 8'h00);
    chk("arst_cury", cursor_y, 8'h00);
    chk("arst_irq", {7'b0, kbd_irq}, 8'h00);
    address = IOB + 16'd7;
    #1 chk("arst_cnt", data_i, 8'h00);
    step();
    reset_n = 1'b1;
    step();
    ps2_hit = 1'b0;
    io_rd(7, 8'h01, "post_rst_cnt");
    io_rd(4, 8'h77, "post_rst_data");

    // Randomized traffic.
    for (int n = 0; n < 2000; n++) begin
      sel = int'($urandom_range(0, 9));
      if (sel < 5) begin
        sel = int'($urandom_range(0, 11));
        address = IOB + 16'((sel > 7) ? 4 : sel);
      end else if (sel < 8) address = WB + 16'($urandom_range(0, 4095));
      else if (sel == 8) begin
        case ($urandom_range(0, 2))
          0: address = IOB - 16'd1;
          1: address = IOB + 16'd8;
          default: address = WB - 16'd1;
        endcase
      end else address = 16'($urandom);
      wren    = ($urandom_range(0, 3) == 0);
      rd      = ($urandom_range(0, 1) == 0);
      data_o  = 8'($urandom);
      if ($urandom_range(0, 4) == 0) ps2_hit = ~ps2_hit;
      ps2_data = 8'($urandom);
      reset_n = ($urandom_range(0, 299) != 0);
      step();
    end
    reset_n = 1'b1; wren = 1'b0; rd = 1'b0;
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
